// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: default widths shared by the operand fetch stage and its forwarding mux
package operand_fetch_stage_pkg;
  localparam int DEF_BIT_SIZE = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CTRL_W = 8;
  localparam int STALL_W = 16;
endpackage

// File: rtl/operand_fetch_stage_fwd_mux.sv
// operand_fetch_stage_fwd_mux: picks r0 zero, then EX/MEM, then MEM/WB bypass, else the registered operand
module operand_fetch_stage_fwd_mux
  import operand_fetch_stage_pkg::*;
#(
  parameter int bit_size = DEF_BIT_SIZE,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [bit_size-1:0] reg_val,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [bit_size-1:0] mem_data,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [bit_size-1:0] wb_data,
  output logic [bit_size-1:0] operand
);
  always_comb
    operand = (addr == '0) ? '0 :
              (mem_we && mem_addr == addr) ? mem_data :
              (wb_we && wb_addr == addr) ? wb_data : reg_val;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID/EX register with regfile write-through, EX/MEM+MEM/WB forwarding, load-use bubble and stall counter
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int bit_size = DEF_BIT_SIZE,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_rs,
  input  logic [ADDR_W-1:0]   in_rt,
  input  logic [ADDR_W-1:0]   in_wr_addr,
  input  logic                in_reg_write,
  input  logic                in_mem_read,
  input  logic [CTRL_W-1:0]   in_ctrl,
  output logic [ADDR_W-1:0]   rf_addr_1,
  output logic [ADDR_W-1:0]   rf_addr_2,
  input  logic [bit_size-1:0] rf_data_1,
  input  logic [bit_size-1:0] rf_data_2,
  input  logic                mem_reg_write,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [bit_size-1:0] mem_data,
  input  logic                wb_reg_write,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [bit_size-1:0] wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bit_size-1:0] out_op_a,
  output logic [bit_size-1:0] out_op_b,
  output logic [ADDR_W-1:0]   out_wr_addr,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [STALL_W-1:0]  stall_cnt
);
  logic [ADDR_W-1:0] rs_q, rt_q;
  logic [bit_size-1:0] op_a_q, op_b_q, cap_a, cap_b;
  logic advance, hazard, wb_a, wb_b;
  assign rf_addr_1 = in_rs;
  assign rf_addr_2 = in_rt;
  assign advance = !out_valid || out_ready;
  assign hazard = out_valid && out_mem_read && out_wr_addr != '0 && in_valid &&
                  (out_wr_addr == in_rs || out_wr_addr == in_rt);
  assign in_ready = rst && advance && !hazard;
  assign wb_a = wb_reg_write && wb_addr == rs_q && rs_q != '0;
  assign wb_b = wb_reg_write && wb_addr == rt_q && rt_q != '0;
  // the regfile commits wb at the same edge we capture, so take wb_data instead of the stale read
  assign cap_a = (in_rs == '0) ? '0 : (wb_reg_write && wb_addr == in_rs) ? wb_data : rf_data_1;
  assign cap_b = (in_rt == '0) ? '0 : (wb_reg_write && wb_addr == in_rt) ? wb_data : rf_data_2;
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      rs_q <= '0;
      rt_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      out_wr_addr <= '0;
      out_reg_write <= 1'b0;
      out_mem_read <= 1'b0;
      out_ctrl <= '0;
      stall_cnt <= '0;
    end else if (advance) begin
      out_valid <= in_valid && !hazard;
      if (in_valid && !hazard) begin
        rs_q <= in_rs;
        rt_q <= in_rt;
        op_a_q <= cap_a;
        op_b_q <= cap_b;
        out_wr_addr <= in_wr_addr;
        out_reg_write <= in_reg_write;
        out_mem_read <= in_mem_read;
        out_ctrl <= in_ctrl;
      end
      if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end else begin
      // held operands track writeback so they are current once the bypass moves on
      if (wb_a) op_a_q <= wb_data;
      if (wb_b) op_b_q <= wb_data;
    end
  end
  operand_fetch_stage_fwd_mux #(.bit_size(bit_size), .ADDR_W(ADDR_W)) u_fwd_a (
    .addr(rs_q), .reg_val(op_a_q), .mem_we(mem_reg_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_we(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data), .operand(out_op_a)
  );
  operand_fetch_stage_fwd_mux #(.bit_size(bit_size), .ADDR_W(ADDR_W)) u_fwd_b (
    .addr(rt_q), .reg_val(op_b_q), .mem_we(mem_reg_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_we(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data), .operand(out_op_b)
  );
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed and random checks against an architectural regfile model
module tb_operand_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_reg_write, in_mem_read;
  logic [4:0] in_rs, in_rt, in_wr_addr, rf_addr_1, rf_addr_2;
  logic [7:0] in_ctrl;
  logic [31:0] rf_data_1, rf_data_2;
  logic mem_reg_write, wb_reg_write;
  logic [4:0] mem_addr, wb_addr;
  logic [31:0] mem_data, wb_data;
  logic out_valid, out_ready, out_reg_write, out_mem_read;
  logic [31:0] out_op_a, out_op_b;
  logic [4:0] out_wr_addr;
  logic [7:0] out_ctrl;
  logic [15:0] stall_cnt;
  logic [31:0] rf [32];
  int n_checks = 0;
  int n_fail = 0;
  logic m_v, m_rw, m_mr;
  logic [4:0] m_rs, m_rt, m_wr;
  logic [7:0] m_ctrl;
  int m_stall;

  always #5 clk = ~clk;

  assign rf_data_1 = rf[rf_addr_1];
  assign rf_data_2 = rf[rf_addr_2];

  operand_fetch_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt),
    .in_wr_addr(in_wr_addr), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_ctrl(in_ctrl),
    .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .mem_reg_write(mem_reg_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_wr_addr(out_wr_addr), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // architectural value of register r as EX should see it now
  function automatic logic [31:0] arch_val(input logic [4:0] r);
    if (r == 0) return 0;
    if (mem_reg_write && mem_addr == r) return mem_data;
    if (wb_reg_write && wb_addr == r) return wb_data;
    return rf[r];
  endfunction

  function automatic logic is_hazard();
    return m_v && m_mr && m_wr != 0 && in_valid && (m_wr == in_rs || m_wr == in_rt);
  endfunction

  task automatic settle_check();
    logic exp_ir;
    #1;
    exp_ir = rst && (!m_v || out_ready) && !is_hazard();
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    check("rf_addr", {22'd0, rf_addr_1, rf_addr_2}, {22'd0, in_rs, in_rt});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_v});
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
    if (m_v) begin
      check("op_a", out_op_a, arch_val(m_rs));
      check("op_b", out_op_b, arch_val(m_rt));
      check("passthru", {16'd0, out_ctrl, out_wr_addr, out_reg_write, out_mem_read},
            {16'd0, m_ctrl, m_wr, m_rw, m_mr});
    end
  endtask

  task automatic clock_edge();
    logic adv, hz;
    adv = !m_v || out_ready;
    hz = is_hazard();
    if (!rst) begin
      m_v = 0;
      m_stall = 0;
    end else if (adv) begin
      m_v = in_valid && !hz;
      if (m_v) begin
        m_rs = in_rs;
        m_rt = in_rt;
        m_wr = in_wr_addr;
        m_rw = in_reg_write;
        m_mr = in_mem_read;
        m_ctrl = in_ctrl;
      end
      if (hz && m_stall < 65535) m_stall++;
    end
    @(posedge clk);
    #1;
    if (wb_reg_write && wb_addr != 0) rf[wb_addr] = wb_data;
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    clock_edge();
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_wr_addr = 0; in_reg_write = 0; in_mem_read = 0; in_ctrl = 0;
    mem_reg_write = 0; mem_addr = 0; mem_data = 0; wb_reg_write = 0; wb_addr = 0; wb_data = 0;
    out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr, input logic ld);
    in_valid = 1; in_rs = rs; in_rt = rt; in_wr_addr = wr; in_reg_write = 1; in_mem_read = ld;
    in_ctrl = 8'h5A ^ {3'd0, wr};
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 0 : 32'h1000 + i;
    m_v = 0; m_stall = 0; m_rs = 0; m_rt = 0; m_wr = 0; m_rw = 0; m_mr = 0; m_ctrl = 0;
    idle();
    rst = 0;
    issue(5'd3, 5'd4, 5'd9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    step();
    settle_check();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    clock_edge();
    rst = 1;
    rf[3] = 32'h11; rf[4] = 32'h22;
    issue(5'd3, 5'd4, 5'd9, 1'b0);
    step();
    idle();
    settle_check();
    check("nohaz_op_a", out_op_a, 32'h11);
    check("nohaz_op_b", out_op_b, 32'h22);
    clock_edge();
    rf[5] = 32'h10;
    issue(5'd5, 5'd0, 5'd9, 1'b0);
    wb_reg_write = 1; wb_addr = 5; wb_data = 32'hAB;
    step();
    idle();
    settle_check();
    check("wthru_op_a", out_op_a, 32'hAB);
    clock_edge();
    issue(5'd7, 5'd0, 5'd9, 1'b0);
    step();
    idle();
    out_ready = 0;
    mem_reg_write = 1; mem_addr = 7; mem_data = 32'h1;
    wb_reg_write = 1; wb_addr = 7; wb_data = 32'h2;
    settle_check();
    check("prio_mem", out_op_a, 32'h1);
    mem_reg_write = 0;
    #1;
    check("prio_wb", out_op_a, 32'h2);
    mem_reg_write = 1; mem_addr = 0; wb_reg_write = 0;
    clock_edge();
    out_ready = 1;
    issue(5'd0, 5'd0, 5'd9, 1'b0);
    step();
    idle();
    mem_reg_write = 1; mem_addr = 0; mem_data = 32'h1;
    wb_reg_write = 1; wb_addr = 0; wb_data = 32'h2;
    settle_check();
    check("zero_op_a", out_op_a, 32'h0);
    clock_edge();
    idle();
    issue(5'd1, 5'd2, 5'd8, 1'b1);
    step();
    issue(5'd8, 5'd0, 5'd10, 1'b0);
    settle_check();
    check("lu_in_ready", {31'd0, in_ready}, 32'd0);
    clock_edge();
    settle_check();
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    check("lu_stall", {16'd0, stall_cnt}, 32'd1);
    check("lu_ready2", {31'd0, in_ready}, 32'd1);
    clock_edge();
    idle();
    wb_reg_write = 1; wb_addr = 8; wb_data = 32'h55;
    settle_check();
    check("lu_op_a", out_op_a, 32'h55);
    clock_edge();
    idle();
    issue(5'd3, 5'd4, 5'd11, 1'b0);
    step();
    idle();
    out_ready = 0;
    wb_reg_write = 1; wb_addr = 4; wb_data = 32'h99;
    step();
    wb_reg_write = 0;
    for (int i = 0; i < 2; i++) begin
      settle_check();
      check("bp_op_b", out_op_b, 32'h99);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      clock_edge();
    end
    out_ready = 1;
    step();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_rs = 5'($urandom_range(0, 7));
      in_rt = 5'($urandom_range(0, 7));
      in_wr_addr = 5'($urandom_range(0, 7));
      in_reg_write = $urandom_range(0, 1);
      in_mem_read = $urandom_range(0, 2) == 0;
      in_ctrl = 8'($urandom);
      mem_reg_write = $urandom_range(0, 2) == 0;
      mem_addr = 5'($urandom_range(0, 7));
      mem_data = $urandom;
      wb_reg_write = $urandom_range(0, 1);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
